jt7759_rom_arb: RTL and testbench

- Shares one external sample-ROM port between two jt7759 control engines (requester 0 and requester 1), e.g. two ADPCM voices on one SDRAM/BRAM channel.
- Each requester sees a private ROM port with a one-byte, address-tagged latch: its `ok` rises only when data for its current address is held.
- The downstream port gets one fetch at a time, granted round-robin, with a watchdog on stalled fetches.

---
 rtl/jt7759_rom_arb_if.sv | 24 ++
 rtl/jt7759_rom_arb.sv | 138 +++++++++++++
 tb/tb_jt7759_rom_arb.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt7759_rom_arb_if.sv
// rtl/jt7759_rom_arb_if.sv - shared sample-ROM read port between arbiter and memory
interface jt7759_rom_arb_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;

    modport master (
        output rom_cs,
        output rom_addr,
        input  rom_data,
        input  rom_ok
    );

    modport slave (
        input  rom_cs,
        input  rom_addr,
        output rom_data,
        output rom_ok
    );
endinterface

// File: rtl/jt7759_rom_arb.sv
// rtl/jt7759_rom_arb.sv - two-requester round-robin arbiter for one sample-ROM port
module jt7759_rom_arb #(
    parameter int AW   = 17,
    parameter int DW   = 8,
    parameter int TOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs0,
    input  logic [AW-1:0]         addr0,
    input  logic                  flush0,
    output logic [DW-1:0]         data0,
    output logic                  ok0,
    input  logic                  cs1,
    input  logic [AW-1:0]         addr1,
    input  logic                  flush1,
    output logic [DW-1:0]         data1,
    output logic                  ok1,
    jt7759_rom_arb_if.master      rom,
    output logic                  err
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t        st_q, st_d;
    logic          g_q, g_d;
    logic          prio_q, prio_d;
    logic          rom_cs_q, rom_cs_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic [AW-1:0] tag_q [2];
    logic [AW-1:0] tag_d [2];
    logic [1:0]    valid_q, valid_d;

    logic [AW-1:0] addr_v [2];
    logic [1:0]    cs_v, flush_v, hit, pend;
    logic          gsel;

    assign addr_v[0] = addr0;
    assign addr_v[1] = addr1;
    assign cs_v      = {cs1, cs0};
    assign flush_v   = {flush1, flush0};

    assign hit[0]  = valid_q[0] && (tag_q[0] == addr0);
    assign hit[1]  = valid_q[1] && (tag_q[1] == addr1);
    assign pend    = cs_v & ~hit;
    // Requester 1 wins when it is the only one missing, or when both miss and it holds priority
    assign gsel    = pend[1] & (~pend[0] | prio_q);

    assign ok0  = cs0 & hit[0];
    assign ok1  = cs1 & hit[1];
    assign data0 = data_q[0];
    assign data1 = data_q[1];

    assign rom.rom_cs   = rom_cs_q;
    assign rom.rom_addr = rom_addr_q;
    assign err          = err_q;

    always_comb begin
        st_d       = st_q;
        g_d        = g_q;
        prio_d     = prio_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        data_d     = data_q;
        tag_d      = tag_q;
        valid_d    = valid_q;

        case (st_q)
            ST_IDLE: begin
                if (|pend) begin
                    g_d        = gsel;
                    rom_addr_d = addr_v[gsel];
                    rom_cs_d   = 1'b1;
                    st_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                // rom_ok here may still belong to the previous fetch
                wcnt_d = 8'd0;
                st_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (rom.rom_ok) begin
                    data_d[g_q]  = rom.rom_data;
                    tag_d[g_q]   = rom_addr_q;
                    valid_d[g_q] = 1'b1;
                    rom_cs_d     = 1'b0;
                    prio_d       = ~g_q;
                    st_d         = ST_IDLE;
                end else if (wcnt_q == 8'(TOUT)) begin
                    rom_cs_d = 1'b0;
                    err_d    = 1'b1;
                    prio_d   = ~g_q;
                    st_d     = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        // Flush overrides a same-cycle completion write
        valid_d = valid_d & ~flush_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            g_q        <= 1'b0;
            prio_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            wcnt_q     <= 8'd0;
            err_q      <= 1'b0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            valid_q    <= 2'b00;
        end else begin
            st_q       <= st_d;
            g_q        <= g_d;
            prio_q     <= prio_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_jt7759_rom_arb.sv
// tb/tb_jt7759_rom_arb.sv - self-checking bench for jt7759_rom_arb
module tb_jt7759_rom_arb;
    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int TOUT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs0 = 1'b0, cs1 = 1'b0, flush0 = 1'b0, flush1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0, data1;
    logic          ok0, ok1, err;

    jt7759_rom_arb_if #(.AW(AW), .DW(DW)) rom_bus ();

    jt7759_rom_arb #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .cs0(cs0), .addr0(addr0), .flush0(flush0), .data0(data0), .ok0(ok0),
        .cs1(cs1), .addr1(addr1), .flush1(flush1), .data1(data1), .ok1(ok1),
        .rom(rom_bus), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Memory responder controls
    int         rc = 0;
    int         lat = 0;
    bit         fixed_en = 1'b0;
    logic [7:0] fixed_val = 8'h00;

    task automatic tick();
        @(posedge clk);
        #2;
        if (rom_bus.rom_cs) rc++; else rc = 0;
        rom_bus.rom_ok   = (lat == 0) || (rom_bus.rom_cs && rc >= lat);
        rom_bus.rom_data = fixed_en ? fixed_val : ((rc <= 1) ? 8'hEE : fn(rom_bus.rom_addr));
    endtask

    // Reference model: a fetch is "busy" from grant until completion/timeout, aged in edges
    bit            m_busy = 0, m_owner = 0, m_prio = 0, m_err = 0;
    int            m_age = 0;
    logic [AW-1:0] m_addr = '0;
    bit            m_valid [2];
    logic [AW-1:0] m_tag [2];
    logic [7:0]    m_data [2];

    always @(posedge clk) begin : model
        bit p0, p1;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_prio = 0; m_err = 0; m_age = 0; m_addr = '0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
            end
        end else begin
            if (!m_busy) begin
                p0 = cs0 && !(m_valid[0] && m_tag[0] == addr0);
                p1 = cs1 && !(m_valid[1] && m_tag[1] == addr1);
                if (p0 || p1) begin
                    m_owner = (p0 && p1) ? m_prio : p1;
                    m_addr  = m_owner ? addr1 : addr0;
                    m_busy  = 1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
                if (m_age >= 2) begin
                    if (rom_bus.rom_ok) begin
                        m_data[m_owner]  = rom_bus.rom_data;
                        m_tag[m_owner]   = m_addr;
                        m_valid[m_owner] = 1;
                        m_busy = 0;
                        m_prio = !m_owner;
                    end else if (m_age - 2 == TOUT) begin
                        m_err  = 1;
                        m_busy = 0;
                        m_prio = !m_owner;
                    end
                end
            end
            if (flush0) m_valid[0] = 0;
            if (flush1) m_valid[1] = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_cs", 32'(rom_bus.rom_cs), 32'(m_busy));
            chk("rom_addr", 32'(rom_bus.rom_addr), 32'(m_addr));
            chk("err", 32'(err), 32'(m_err));
            chk("ok0", 32'(ok0), 32'(cs0 && m_valid[0] && m_tag[0] == addr0));
            chk("ok1", 32'(ok1), 32'(cs1 && m_valid[1] && m_tag[1] == addr1));
            chk("data0", 32'(data0), 32'(m_data[0]));
            chk("data1", 32'(data1), 32'(m_data[1]));
        end
    end

    // Fetch monitor: grant owner by address bit 16, and idle gap before each fetch
    int  rises = 0;
    int  lowrun = 0;
    bit  prev_cs = 0;
    bit  grants[$];
    int  gaps[$];

    always @(negedge clk) begin
        if (rom_bus.rom_cs === 1'b1 && !prev_cs) begin
            rises++;
            grants.push_back(rom_bus.rom_addr[16]);
            gaps.push_back(lowrun);
        end
        if (rom_bus.rom_cs === 1'b1) lowrun = 0; else lowrun++;
        prev_cs = (rom_bus.rom_cs === 1'b1);
    end

    task automatic do_reset();
        rst = 1; cs0 = 0; cs1 = 0; flush0 = 0; flush1 = 0; addr0 = '0; addr1 = '0;
        tick();
        tick();
        rst = 0;
        chk_en = 1;
    endtask

    task automatic wait_ok(input bit which, input int budget, input string name);
        int n = 0;
        while (n < budget && !(which ? ok1 : ok0)) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk(name, 32'(which ? ok1 : ok0), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base, r0;
        rom_bus.rom_ok   = 1'b0;
        rom_bus.rom_data = 8'h00;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_rom_cs", 32'(rom_bus.rom_cs), 32'd0);
        chk("rst_rom_addr", 32'(rom_bus.rom_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data0", 32'(data0), 32'd0);

        // Single hit path
        lat = 0; fixed_en = 1; fixed_val = 8'h5A;
        r0 = rises;
        tick(); cs0 = 1; addr0 = 17'h00123;
        tick(); @(negedge clk);
        chk("hit_cs", 32'(rom_bus.rom_cs), 32'd1);
        chk("hit_addr", 32'(rom_bus.rom_addr), 32'h00123);
        chk("hit_ok0_e1", 32'(ok0), 32'd0);
        tick(); @(negedge clk);
        chk("hit_ok0_e2", 32'(ok0), 32'd0);
        tick(); @(negedge clk);
        chk("hit_ok0_e3", 32'(ok0), 32'd1);
        chk("hit_data0", 32'(data0), 32'h5A);
        repeat (6) tick();
        chk("hit_one_fetch", 32'(rises - r0), 32'd1);

        // Round-robin contention
        do_reset();
        lat = 3; fixed_en = 0;
        base = grants.size();
        tick(); cs0 = 1; cs1 = 1; addr0 = 17'h00200; addr1 = 17'h10300;
        for (int i = 0; i < 80 && grants.size() < base + 5; i++) begin
            tick();
            if (ok0) addr0 = addr0 + 17'd1;
            if (ok1) addr1 = addr1 + 17'd1;
        end
        chk("rr_budget", 32'(grants.size() >= base + 5), 32'd1);
        if (grants.size() >= base + 4) begin
            chk("rr_g0", 32'(grants[base + 0]), 32'd0);
            chk("rr_g1", 32'(grants[base + 1]), 32'd1);
            chk("rr_g2", 32'(grants[base + 2]), 32'd0);
            chk("rr_g3", 32'(grants[base + 3]), 32'd1);
            chk("rr_gap1", 32'(gaps[base + 1]), 32'd1);
            chk("rr_gap2", 32'(gaps[base + 2]), 32'd1);
            chk("rr_gap3", 32'(gaps[base + 3]), 32'd1);
        end

        // Stale ok rejection: REQ cycle presents 0xEE with rom_ok high
        do_reset();
        lat = 0; fixed_en = 0;
        tick(); cs0 = 1; addr0 = 17'h004A7;
        wait_ok(0, 10, "stale_ok0");
        chk("stale_data0", 32'(data0), 32'h9F);

        // Address change mid-fetch
        do_reset();
        lat = 3;
        tick(); cs0 = 1; addr0 = 17'h00010;
        tick();
        tick(); addr0 = 17'h00011;
        tick();
        tick();
        chk("mid_ok0_new", 32'(ok0), 32'd0);
        addr0 = 17'h00010;
        #1;
        chk("mid_ok0_old", 32'(ok0), 32'd1);
        chk("mid_data0_old", 32'(data0), 32'h2C);
        tick(); addr0 = 17'h00011;
        tick(); @(negedge clk);
        chk("mid_refetch_cs", 32'(rom_bus.rom_cs), 32'd1);
        chk("mid_refetch_addr", 32'(rom_bus.rom_addr), 32'h00011);
        wait_ok(0, 12, "mid_ok0_final");
        chk("mid_data0_final", 32'(data0), 32'h2D);

        // Flush colliding with completion
        do_reset();
        lat = 0;
        tick(); cs1 = 1; addr1 = 17'h10040;
        tick();
        tick(); flush1 = 1;
        tick(); flush1 = 0;
        @(negedge clk);
        chk("flush_ok1", 32'(ok1), 32'd0);
        tick(); @(negedge clk);
        chk("flush_refetch_cs", 32'(rom_bus.rom_cs), 32'd1);
        chk("flush_refetch_addr", 32'(rom_bus.rom_addr), 32'h10040);
        wait_ok(1, 10, "flush_ok1_final");
        chk("flush_data1", 32'(data1), 32'h7C);

        // Timeout, then reset during WAIT
        do_reset();
        lat = 99;
        tick(); cs0 = 1; addr0 = 17'h00055; cs1 = 1; addr1 = 17'h10066;
        repeat (5) tick();
        tick(); @(negedge clk);
        chk("to_still_waiting", 32'(rom_bus.rom_cs), 32'd1);
        chk("to_err_before", 32'(err), 32'd0);
        tick(); @(negedge clk);
        chk("to_cs_drop", 32'(rom_bus.rom_cs), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        tick(); @(negedge clk);
        chk("to_next_cs", 32'(rom_bus.rom_cs), 32'd1);
        chk("to_next_addr", 32'(rom_bus.rom_addr), 32'h10066);
        tick();
        tick(); rst = 1; cs0 = 0; cs1 = 0; lat = 0;
        tick(); @(negedge clk);
        chk("rr_rst_cs", 32'(rom_bus.rom_cs), 32'd0);
        chk("rr_rst_addr", 32'(rom_bus.rom_addr), 32'd0);
        chk("rr_rst_err", 32'(err), 32'd0);
        chk("rr_rst_data1", 32'(data1), 32'd0);
        tick(); rst = 0;
        tick(); @(negedge clk);
        chk("post_rst_cs", 32'(rom_bus.rom_cs), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
